// File: rtl/uart_pkg.sv
// Constants and state type shared by the UART transmit and receive paths.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_9600_100M = 10417;
  localparam int unsigned UART_DATA_BITS         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Restartable bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last cycle of each period.
module uart_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned CNT_W        = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic             o_bit_end,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LastCnt);
  assign o_bit_end = i_en && w_at_last;
  assign o_cnt     = r_cnt;

  // Clear takes priority so the period is aligned to the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter: one byte per valid/ready handshake, sent as
// start bit, 8 data bits LSB first, stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600_100M,
  parameter int unsigned CNT_W        = 14,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [CNT_W-1:0]     bit_cnt_dbg
);

  localparam int unsigned      IdxW    = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(DATA_BITS - 1);

  tx_state_e             r_state;
  logic [DATA_BITS-1:0]  r_shift;
  logic [IdxW-1:0]       r_idx;
  logic                  r_tx;
  logic                  r_done;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_bit_end;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = tx_valid && w_idle;

  assign tx_ready = w_idle;
  assign tx_busy  = !w_idle;
  assign tx       = r_tx;
  assign tx_done  = r_done;

  uart_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_en      (!w_idle),
    .o_bit_end (w_bit_end),
    .o_cnt     (bit_cnt_dbg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= tx_data;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            if (r_idx == LastIdx) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              // Next bit is the one about to land in r_shift[0].
              r_tx  <= r_shift[1];
              r_idx <= r_idx + IdxW'(1);
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at CLKS_PER_BIT=4 against a
// frame-level reference model (line level derived from accept time and byte).
module tb_uart_transmitter;

  localparam int C  = 4;
  localparam int FR = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] bit_cnt_dbg;

  int         n_tests = 0;
  int         n_fail = 0;

  // Reference model: edge counter, accept edge and latched byte of the last frame.
  longint     e = 0;
  bit         m_act = 1'b0;
  longint     m_a = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ready = 1'b1;
  bit         rec = 1'b0;
  bit         line_q[$];

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT (C),
    .CNT_W        (3),
    .DATA_BITS    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .bit_cnt_dbg (bit_cnt_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  function automatic logic [7:0] decode(input int s);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = line_q[s + (j + 1) * C + C / 2];
    return b;
  endfunction

  // One clock: update the model at the edge, then compare all outputs.
  task automatic step();
    longint k;
    bit     busy;
    @(posedge clk);
    e++;
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (tx_valid && m_ready) begin
      m_act  = 1'b1;
      m_a    = e;
      m_byte = tx_data;
    end
    #1;
    k       = e - m_a;
    busy    = m_act && (k < FR);
    m_ready = !busy;
    check_eq("tx", 32'(tx), 32'(busy ? frame_bit(m_byte, int'(k / C)) : 1'b1));
    check_eq("tx_ready", 32'(tx_ready), 32'(!busy));
    check_eq("tx_busy", 32'(tx_busy), 32'(busy));
    check_eq("tx_done", 32'(tx_done), 32'(m_act && (k == FR)));
    check_eq("bit_cnt", 32'(bit_cnt_dbg), busy ? 32'(k % C) : 32'd0);
    if (rec) line_q.push_back(tx);
  endtask

  // Send one byte; report low-level cycles and edges from accept to tx_done.
  task automatic run_frame(input logic [7:0] b, output int lows, output int len);
    line_q.delete();
    rec      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = b;
    step();
    tx_valid = 1'b0;
    lows     = (tx == 1'b0) ? 1 : 0;
    len      = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      step();
      len++;
      if (tx == 1'b0) lows++;
      if (tx_done) break;
    end
    rec = 1'b0;
    check_eq("frame_done_seen", 32'(tx_done), 32'd1);
  endtask

  initial begin
    int lows;
    int len;
    int mark;
    int idx;
    int dones;
    bit got;

    repeat (2) step();
    rst_n = 1'b1;
    repeat (50) step();

    run_frame(8'h00, lows, len);
    check_eq("x00_lows", 32'(lows), 32'(9 * C));
    check_eq("x00_len", 32'(len), 32'(FR));
    run_frame(8'hFF, lows, len);
    check_eq("xFF_lows", 32'(lows), 32'(C));
    check_eq("xFF_len", 32'(len), 32'(FR));
    check_eq("xFF_decode", 32'(decode(0)), 32'h00FF);

    // Back-to-back with tx_valid held high.
    line_q.delete();
    rec      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA3;
    step();
    tx_data = 8'h3C;
    got     = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      if (tx_done) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("b2b_done1", 32'(got), 32'd1);
    check_eq("b2b_ready_at_done", 32'(tx_ready), 32'd1);
    step();
    check_eq("b2b_second_accept", 32'(tx_busy), 32'd1);
    tx_valid = 1'b0;
    got      = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      if (tx_done) begin
        got = 1'b1;
        break;
      end
    end
    rec = 1'b0;
    check_eq("b2b_done2", 32'(got), 32'd1);
    mark = 0;
    idx  = 9 * C;
    while (idx < line_q.size() && line_q[idx] == 1'b1) begin
      mark++;
      idx++;
    end
    check_eq("b2b_mark", 32'(mark), 32'(C + 1));
    check_eq("b2b_byte1", 32'(decode(0)), 32'h00A3);
    check_eq("b2b_byte2", 32'(decode(9 * C + mark)), 32'h003C);

    // tx_valid pulse while busy must be ignored.
    line_q.delete();
    rec      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    step();
    tx_valid = 1'b0;
    repeat (10) step();
    check_eq("ign_ready_before", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h12;
    step();
    check_eq("ign_ready_after", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    dones    = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      if (tx_done) dones++;
    end
    rec = 1'b0;
    check_eq("ign_dones", 32'(dones), 32'd1);
    check_eq("ign_byte", 32'(decode(0)), 32'h0081);

    // Asynchronous reset during data bit 3 of 0xC6.
    tx_valid = 1'b1;
    tx_data  = 8'hC6;
    step();
    tx_valid = 1'b0;
    repeat (17) step();
    #2;
    rst_n   = 1'b0;
    m_act   = 1'b0;
    m_ready = 1'b1;
    #1;
    check_eq("rst_async_tx", 32'(tx), 32'd1);
    check_eq("rst_async_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_async_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_async_cnt", 32'(bit_cnt_dbg), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    run_frame(8'hC6, lows, len);
    check_eq("rst_refresh_len", 32'(len), 32'(FR));
    check_eq("rst_refresh_byte", 32'(decode(0)), 32'h00C6);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    repeat (FR + 5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
